// File: rtl/perf_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : perf_monitor_if
// Description : Word-addressed read/control-write port of the performance
//               monitor. The master issues reads and control writes; the
//               slave (perf_monitor) returns registered read data.
// Revision    : 1.0 - initial release
// ============================================================================
interface perf_monitor_if #(
    parameter int WIDTH = 32
) ();
    logic             rd_en;
    logic [2:0]       rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             wr_en;
    logic [2:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data, rd_valid
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data, rd_valid
    );
endinterface
`default_nettype wire

// File: rtl/perf_monitor.sv
`default_nettype none
// ============================================================================
// Module      : perf_monitor
// Description : Counts run cycles, retired instructions, stalls, coprocessor
//               busy cycles and coprocessor completions while in RUN. Counts
//               freeze on halt and are readable through a word-addressed port.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_monitor #(
    parameter int WIDTH = 32
) (
    input  wire logic       clk,
    input  wire logic       cycle_count_rst,
    input  wire logic       en,
    input  wire logic       instr_retire,
    input  wire logic       stall,
    input  wire logic       hlt,
    input  wire logic       coproc_busy,
    input  wire logic       coproc_done,
    perf_monitor_if.slave   bus,
    output logic [1:0]      state,
    output logic            halted
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [4:0][WIDTH-1:0]   cnt_q, cnt_d;
    logic [4:0]              ovf_q, ovf_d;
    logic [1:0]              ctrl_q, ctrl_d;
    logic                    prev_hlt_q, prev_hlt_d;
    logic                    prev_done_q, prev_done_d;
    logic [WIDTH-1:0]        rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;

    logic                    ctrl_wr;
    logic                    clr;
    logic                    frz;
    logic                    hlt_rise;
    logic                    done_rise;
    logic [4:0]              inc;
    logic                    unused_wr_data;

    // Decode control writes and event edges; clear overrides freeze.
    always_comb begin
        ctrl_wr        = bus.wr_en && (bus.wr_addr == 3'd7);
        clr            = ctrl_wr && bus.wr_data[0];
        frz            = ctrl_wr && bus.wr_data[1] && !bus.wr_data[0];
        hlt_rise       = hlt && !prev_hlt_q;
        done_rise      = coproc_done && !prev_done_q;
        inc            = {done_rise, coproc_busy, stall, instr_retire, 1'b1}
                         & {5{state_q == ST_RUN}};
        unused_wr_data = ^bus.wr_data[WIDTH-1:2];
    end

    // Next-state logic: IDLE/RUN follow en, RUN freezes on halt edge or
    // freeze write, only a clear write leaves FROZEN.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (en) state_d = ST_RUN;
                ST_RUN: begin
                    if (hlt_rise || frz) state_d = ST_FROZEN;
                    else if (!en)        state_d = ST_IDLE;
                end
                ST_FROZEN: state_d = ST_FROZEN;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Counter, sticky overflow, ctrl readback and edge-history updates.
    always_comb begin
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        ctrl_d      = ctrl_wr ? bus.wr_data[1:0] : ctrl_q;
        prev_hlt_d  = hlt;
        prev_done_d = coproc_done;
        for (int i = 0; i < 5; i++) begin
            if (inc[i]) begin
                cnt_d[i] = cnt_q[i] + C_ONE;
                if (&cnt_q[i]) ovf_d[i] = 1'b1;
            end
        end
        if (clr) begin
            cnt_d = '0;
            ovf_d = '0;
        end
    end

    // Read mux samples current register values, so reads see pre-update state.
    always_comb begin
        rd_valid_d = bus.rd_en;
        rd_data_d  = rd_data_q;
        if (bus.rd_en) begin
            case (bus.rd_addr)
                3'd0:    rd_data_d = cnt_q[0];
                3'd1:    rd_data_d = cnt_q[1];
                3'd2:    rd_data_d = cnt_q[2];
                3'd3:    rd_data_d = cnt_q[3];
                3'd4:    rd_data_d = cnt_q[4];
                3'd5:    rd_data_d = WIDTH'(ovf_q);
                3'd6:    rd_data_d = WIDTH'({state_q == ST_FROZEN, state_q});
                default: rd_data_d = WIDTH'(ctrl_q);
            endcase
        end
    end

    // State register with asynchronous clear of everything.
    always_ff @(posedge clk or posedge cycle_count_rst) begin
        if (cycle_count_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ovf_q       <= '0;
            ctrl_q      <= '0;
            prev_hlt_q  <= 1'b0;
            prev_done_q <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            ctrl_q      <= ctrl_d;
            prev_hlt_q  <= prev_hlt_d;
            prev_done_q <= prev_done_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign state        = state_q;
    assign halted       = (state_q == ST_FROZEN);

endmodule
`default_nettype wire

// File: tb/tb_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_perf_monitor
// Description : Self-checking bench for perf_monitor. A 32-bit instance covers
//               the main function; a 4-bit instance reaches counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic en_s = 1'b0;
    logic instr_retire = 1'b0;
    logic stall = 1'b0;
    logic hlt = 1'b0;
    logic coproc_busy = 1'b0;
    logic coproc_done = 1'b0;
    logic [1:0] state, state_s;
    logic halted, halted_s;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd_q[$];
    logic [3:0]  rd_q_s[$];

    perf_monitor_if #(.WIDTH(32)) bus ();
    perf_monitor_if #(.WIDTH(4))  bus_s ();

    perf_monitor #(.WIDTH(32)) dut (
        .clk(clk), .cycle_count_rst(rst), .en(en),
        .instr_retire(instr_retire), .stall(stall), .hlt(hlt),
        .coproc_busy(coproc_busy), .coproc_done(coproc_done),
        .bus(bus), .state(state), .halted(halted)
    );

    perf_monitor #(.WIDTH(4)) dut_s (
        .clk(clk), .cycle_count_rst(rst), .en(en_s),
        .instr_retire(instr_retire), .stall(stall), .hlt(hlt),
        .coproc_busy(coproc_busy), .coproc_done(coproc_done),
        .bus(bus_s), .state(state_s), .halted(halted_s)
    );

    always #5 clk = ~clk;

    // Scoreboard: every rd_valid pops the oldest expected read value.
    always @(negedge clk) begin
        logic [31:0] e;
        logic [3:0]  es;
        if (bus.rd_valid) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_valid_extra got rd_data=%h with no read pending", bus.rd_data);
            end else begin
                e = rd_q.pop_front();
                if (bus.rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data got=%h exp=%h", bus.rd_data, e);
                end
            end
        end
        if (bus_s.rd_valid) begin
            checks++;
            if (rd_q_s.size() == 0) begin
                errors++;
                $display("FAIL rd_valid_extra_w4 got rd_data=%h with no read pending", bus_s.rd_data);
            end else begin
                es = rd_q_s.pop_front();
                if (bus_s.rd_data !== es) begin
                    errors++;
                    $display("FAIL rd_data_w4 got=%h exp=%h", bus_s.rd_data, es);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        rd_q.push_back(e);
        @(negedge clk);
        bus.rd_en   = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic rd_s(input logic [2:0] a, input logic [3:0] e);
        bus_s.rd_en   = 1'b1;
        bus_s.rd_addr = a;
        rd_q_s.push_back(e);
        @(negedge clk);
        bus_s.rd_en   = 1'b0;
    endtask

    task automatic wr_s(input logic [2:0] a, input logic [3:0] d);
        bus_s.wr_en   = 1'b1;
        bus_s.wr_addr = a;
        bus_s.wr_data = d;
        @(negedge clk);
        bus_s.wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        tick(2);
        checks++;
        if (state !== 2'd0 || halted !== 1'b0 || bus.rd_data !== 32'd0 || bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got state=%0d halted=%b rd_data=%h rd_valid=%b exp 0/0/0/0",
                     state, halted, bus.rd_data, bus.rd_valid);
        end
        checks++;
        if (state_s !== 2'd0 || halted_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs_w4 got state=%0d halted=%b exp 0/0", state_s, halted_s);
        end
        rst = 1'b0;
        tick(1);
        for (int a = 0; a < 8; a++) rd(3'(a), 32'd0);
    endtask

    task automatic test_run_cycles();
        en = 1'b1;
        tick(100);
        en = 1'b0;
        tick(1);
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL run_cycles_state got=%0d exp=0", state);
        end
        bus.rd_en   = 1'b1;
        bus.rd_addr = 3'd0;
        rd_q.push_back(32'd100);
        @(negedge clk);
        bus.rd_en   = 1'b0;
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'd100) begin
            errors++;
            $display("FAIL read_latency got valid=%b data=%0d exp valid=1 data=100", bus.rd_valid, bus.rd_data);
        end
        @(negedge clk);
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid_pulse got=%b exp=0", bus.rd_valid);
        end
        rd(3'd1, 32'd0);
    endtask

    task automatic test_instr_stall_halt();
        wr(3'd7, 32'h1);
        en = 1'b1;
        tick(1);
        for (int i = 0; i < 59; i++) begin
            instr_retire = (i % 3 != 0);
            stall        = (i % 4 == 0);
            tick(1);
        end
        instr_retire = 1'b1;
        stall        = 1'b0;
        hlt          = 1'b1;
        tick(1);
        instr_retire = 1'b0;
        checks++;
        if (state !== 2'd2 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_freeze got state=%0d halted=%b exp 2/1", state, halted);
        end
        for (int i = 0; i < 50; i++) begin
            instr_retire = i[0];
            stall        = 1'b1;
            tick(1);
        end
        instr_retire = 1'b0;
        stall        = 1'b0;
        rd(3'd0, 32'd60);
        rd(3'd1, 32'd40);
        rd(3'd2, 32'd15);
        rd(3'd6, 32'd6);
    endtask

    task automatic test_idle_hlt();
        en = 1'b0;
        wr(3'd7, 32'h1);
        hlt = 1'b0;
        tick(1);
        hlt = 1'b1;
        tick(2);
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL idle_ignores_hlt got state=%0d exp=0", state);
        end
        en = 1'b1;
        tick(1);
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL run_with_hlt_level got state=%0d exp=1", state);
        end
        en  = 1'b0;
        hlt = 1'b0;
        tick(1);
    endtask

    task automatic test_coproc();
        wr(3'd7, 32'h1);
        coproc_busy = 1'b1;
        repeat (2) begin
            coproc_done = 1'b1;
            tick(1);
            coproc_done = 1'b0;
            tick(1);
        end
        coproc_busy = 1'b0;
        en = 1'b1;
        tick(1);
        for (int i = 0; i < 300; i++) begin
            coproc_busy = (i % 10 < 7);
            coproc_done = ((i / 20) % 2 == 1);
            tick(1);
        end
        coproc_busy = 1'b0;
        coproc_done = 1'b0;
        en = 1'b0;
        tick(1);
        rd(3'd3, 32'd210);
        rd(3'd4, 32'd7);
        rd(3'd0, 32'd301);
        rd(3'd1, 32'd0);
    endtask

    task automatic test_back_to_back();
        wr(3'd7, 32'h1);
        en = 1'b1;
        tick(1);
        for (int k = 0; k < 5; k++) rd(3'd0, 32'(k));
        en = 1'b0;
        tick(1);
        rd(3'd0, 32'd6);
        tick(3);
        checks++;
        if (bus.rd_data !== 32'd6 || bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_data_hold got data=%0d valid=%b exp 6/0", bus.rd_data, bus.rd_valid);
        end
    endtask

    task automatic test_clear();
        wr(3'd7, 32'h1);
        en = 1'b1;
        tick(5);
        instr_retire = 1'b1;
        stall        = 1'b1;
        en           = 1'b0;
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 3'd7;
        bus.wr_data  = 32'h3;
        bus.rd_en    = 1'b1;
        bus.rd_addr  = 3'd0;
        rd_q.push_back(32'd4);
        @(negedge clk);
        bus.wr_en    = 1'b0;
        bus.rd_en    = 1'b0;
        instr_retire = 1'b0;
        stall        = 1'b0;
        checks++;
        if (state !== 2'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL clear_wins got state=%0d halted=%b exp 0/0", state, halted);
        end
        rd(3'd0, 32'd0);
        rd(3'd1, 32'd0);
        rd(3'd2, 32'd0);
        rd(3'd5, 32'd0);
        rd(3'd6, 32'd0);
        rd(3'd7, 32'd3);
        en = 1'b1;
        tick(1);
        en = 1'b0;
        wr(3'd7, 32'h2);
        checks++;
        if (state !== 2'd2 || halted !== 1'b1) begin
            errors++;
            $display("FAIL freeze_write got state=%0d halted=%b exp 2/1", state, halted);
        end
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd3;
        bus.wr_data = 32'h1;
        rd(3'd7, 32'd2);
        bus.wr_en   = 1'b0;
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL wrong_addr_write got state=%0d exp=2", state);
        end
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd7;
        bus.wr_data = 32'h1;
        rd(3'd7, 32'd2);
        bus.wr_en   = 1'b0;
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL unfreeze_clear got state=%0d exp=0", state);
        end
        rd(3'd7, 32'd1);
    endtask

    task automatic test_wrap();
        en_s = 1'b1;
        tick(14);
        en_s = 1'b0;
        tick(1);
        rd_s(3'd0, 4'hE);
        rd_s(3'd5, 4'h0);
        en_s = 1'b1;
        tick(3);
        en_s = 1'b0;
        tick(1);
        checks++;
        if (state_s !== 2'd0) begin
            errors++;
            $display("FAIL wrap_state got=%0d exp=0", state_s);
        end
        rd_s(3'd0, 4'h1);
        rd_s(3'd5, 4'h1);
        wr_s(3'd7, 4'h1);
        rd_s(3'd5, 4'h0);
        rd_s(3'd0, 4'h0);
    endtask

    task automatic test_async_reset();
        en = 1'b1;
        tick(6);
        rd(3'd0, 32'd5);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (state !== 2'd0 || halted !== 1'b0 || bus.rd_data !== 32'd0 || bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got state=%0d halted=%b rd_data=%h rd_valid=%b exp 0/0/0/0",
                     state, halted, bus.rd_data, bus.rd_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        tick(4);
        en = 1'b0;
        tick(1);
        rd(3'd0, 32'd4);
        rd(3'd1, 32'd0);
        rd(3'd7, 32'd0);
    endtask

    initial begin
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus_s.rd_en   = 1'b0;
        bus_s.rd_addr = '0;
        bus_s.wr_en   = 1'b0;
        bus_s.wr_addr = '0;
        bus_s.wr_data = '0;

        test_reset();
        test_run_cycles();
        test_instr_stall_halt();
        test_idle_hlt();
        test_coproc();
        test_back_to_back();
        test_clear();
        test_wrap();
        test_async_reset();

        tick(2);
        checks++;
        if (rd_q.size() != 0 || rd_q_s.size() != 0) begin
            errors++;
            $display("FAIL reads_outstanding got=%0d/%0d exp=0/0", rd_q.size(), rd_q_s.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/perf_monitor.md
# perf_monitor

Hardware performance-monitor block inside the Microprocessor top level, alongside the CPU core and image coprocessor. It counts run cycles, retired instructions, pipeline stalls, coprocessor busy cycles and coprocessor completion events. It freezes all counts on halt and exposes them through a small word-addressed read/write port, so software and the simulation environment read the same figures. It takes the cycle/instruction accounting out of the testbench and puts it in silicon.

## Interface
- WIDTH, 32, width of every counter and of rd_data/wr_data
- clk  in  1  system clock, all state on rising edge
- cycle_count_rst  in  1  reset, asynchronous, active-high; clears all state
- en  in  1  level run enable from top level
- instr_retire  in  1  one-cycle pulse per instruction advance (IF-stage PC_EN)
- stall  in  1  pipeline stall level
- hlt  in  1  CPU halt level
- coproc_busy  in  1  coprocessor busy level (COPROC_STS[0])
- coproc_done  in  1  coprocessor done level (COPROC_STS[1])
- rd_en  in  1  read strobe
- rd_addr  in  3  read word index
- rd_data  out  WIDTH  registered read data
- rd_valid  out  1  rd_data valid, one-cycle pulse
- wr_en  in  1  control write strobe, effective only when wr_addr = 7
- wr_addr  in  3  write word index
- wr_data  in  WIDTH  bit0 = clear, bit1 = freeze; other bits ignored
- state  out  2  FSM state: 0 IDLE, 1 RUN, 2 FROZEN
- halted  out  1  high while in FROZEN

## Operation
- FSM:
  - IDLE → RUN when en = 1.
  - RUN → IDLE when en = 0.
  - RUN → FROZEN on rising edge of hlt, or on a ctrl write with bit1 = 1.
  - FROZEN → IDLE only on a ctrl write with bit0 = 1.
  - IDLE ignores hlt.
- Counters. All increment only while state = RUN, evaluated on the cycle before the edge:
  - C0 cycles: +1 every RUN cycle.
  - C1 instrs: +1 when instr_retire = 1.
  - C2 stalls: +1 when stall = 1.
  - C3 cp_busy: +1 when coproc_busy = 1.
  - C4 cp_done: +1 on rising edge of coproc_done. The edge detector's previous-value register resets to 0 and updates every cycle in every state.
- Arithmetic: each counter wraps modulo 2^WIDTH. Incrementing from all-ones sets that counter's sticky ovf bit (ovf[4:0], bit i for Ci). ovf clears only on reset or clear.
- Clear write (bit0 = 1), in any state:
  - All counters and ovf go to 0 next edge; state goes to IDLE.
  - Clear has priority over any increment in the same cycle.
  - If bit0 and bit1 are both set, clear wins and freeze is ignored.
- Read map (rd_addr):
  - 0–4: C0–C4.
  - 5: {zeros, ovf[4:0]}.
  - 6: {zeros, halted, state[1:0]}.
  - 7: last ctrl value written, bits[1:0], zero-extended.
- Simultaneous events:
  - hlt rising together with instr_retire: the retire is counted; counting stops from the next cycle.
  - Read on the same edge as an increment returns the pre-increment value.
  - Read and write in the same cycle: the read returns the pre-write value.
- Reset mid-operation: everything returns to reset values immediately (asynchronous); no partial counts survive.

## Timing
- Reset values: rd_data = 0, rd_valid = 0, state = IDLE(0), halted = 0. Counters, ovf, ctrl readback and edge-detect register all = 0.
- Read latency is 1 cycle: rd_en sampled at edge N, then rd_data/rd_valid valid after edge N. rd_valid is high for exactly one cycle per rd_en. Back-to-back reads are supported every cycle.
- rd_data holds its last value when rd_en = 0.
- en change takes effect at the next edge: the first RUN cycle counts C0 at the edge after the one that entered RUN.
- hlt rising edge detected on a registered previous value. FROZEN is entered at the edge where hlt = 1 and prev_hlt = 0. The cycle that sampled the rising edge is still counted.
- Control write takes effect at the edge where wr_en is sampled.

## Test plan
- Reset, then en = 1 for 100 cycles, then en = 0 → C0 = 100, C1 = 0, state = IDLE. A read of addr 0 returns 100 with rd_valid one cycle after rd_en.
- RUN with instr_retire pulsed 40 times and stall high 15 cycles, then hlt rising → C1 = 40, C2 = 15, halted = 1, state = 2. C0 unchanged across 50 further cycles.
- coproc_done toggled through 7 rising edges, with coproc_busy high for 210 total cycles in RUN → C4 = 7, C3 = 210. Edges occurring in IDLE are not counted.
- Preload C0 = 0xFFFF_FFFE via forced state, run 3 cycles → C0 = 1, ovf[0] = 1. Read of addr 5 returns 0x1.
- Ctrl write 0x3 while an increment is pending → all counters 0, ovf 0, state IDLE; freeze ignored. Read of addr 7 returns 0x3.
- Assert cycle_count_rst mid-RUN without a clock edge → all outputs 0 immediately. After release with en = 1, counting restarts from 0.
